// File: rtl/mem_responder.sv
// Purpose: cpu-bus memory responder: word RAM plus MMIO window (TX byte FIFO, RX holding reg, cycle counter).
// Latency: read data is combinational from address/state; every state update lands on posedge clk.
// Backpressure: TX drains on tx_valid&tx_ready, a push into a full FIFO with no pop drops the byte and sets ovf; rx_ready is low while the holding reg is full.
// Ports: clk, reset (async, active-low); cpu bus address/datao/rw in, data out;
//        tx_data/tx_valid/tx_ready outgoing byte stream; rx_data/rx_valid/rx_ready incoming byte stream.
module mem_responder #(
  parameter int ADDR_BITS  = 10,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] datao,
  input  logic        rw,
  output logic [31:0] data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int RAM_WORDS = 1 << ADDR_BITS;

  // Storage arrays: neither is reset. FIFO slots are only visible through
  // tx_data while occupied, so stale contents never leak out.
  logic [31:0] ram      [RAM_WORDS];
  logic [7:0]  fifo_mem [FIFO_DEPTH];

  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             rx_full_q, rx_full_d;
  logic [7:0]       held_q, held_d;
  logic [31:0]      cyc_q, cyc_d;
  logic [31:0]      la_q, la_d;
  logic             lr_q, lr_d;
  logic             lv_q, lv_d;

  logic        is_ram, is_mmio, new_acc;
  logic [7:0]  offset;
  logic        tx_empty, tx_full, tx_pop, tx_push_req, tx_push;
  logic        sts_wr, rx_pop, cyc_ld, rx_cap, ram_wr;
  logic [31:0] cnt_ext;
  logic [3:0]  cnt_sat;

  // Address decode and access-run detection. A held access (same address
  // and direction as last cycle) is not new, so side effects fire once.
  always_comb begin
    is_ram      = (address[31:ADDR_BITS] == '0);
    is_mmio     = (address[31:8] == 24'hFFFFFF);
    offset      = address[7:0];
    new_acc     = !lv_q || (address != la_q) || (rw != lr_q);
    ram_wr      = is_ram && !rw;
    tx_push_req = is_mmio && (offset == 8'h00) && !rw && new_acc;
    sts_wr      = is_mmio && (offset == 8'h01) && !rw && new_acc;
    rx_pop      = is_mmio && (offset == 8'h02) &&  rw && new_acc;
    cyc_ld      = is_mmio && (offset == 8'h03) && !rw && new_acc;
  end

  // TX FIFO control. A push into a full FIFO is still accepted when the
  // head leaves in the same cycle.
  always_comb begin
    tx_empty = (cnt_q == '0);
    tx_full  = (cnt_q == CNT_W'(FIFO_DEPTH));
    tx_valid = !tx_empty;
    tx_pop   = tx_valid && tx_ready;
    tx_push  = tx_push_req && (!tx_full || tx_pop);
    tx_data  = tx_empty ? 8'h00 : fifo_mem[rptr_q];
    rx_ready = !rx_full_q;
    rx_cap   = rx_valid && !rx_full_q;
  end

  // Next-state logic for all control registers.
  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    cnt_d     = cnt_q + CNT_W'(tx_push) - CNT_W'(tx_pop);
    ovf_d     = ovf_q;
    rx_full_d = rx_full_q;
    held_d    = held_q;
    cyc_d     = cyc_q + 32'd1;
    la_d      = address;
    lr_d      = rw;
    lv_d      = 1'b1;

    if (tx_push) wptr_d = wptr_q + PTR_W'(1);
    if (tx_pop)  rptr_d = rptr_q + PTR_W'(1);

    // Drop and clear come from different offsets, so they never coincide.
    if (tx_push_req && !tx_push) ovf_d = 1'b1;
    if (sts_wr)                  ovf_d = 1'b0;

    // Pop only matters while full; capture only happens while empty.
    if (rx_pop) rx_full_d = 1'b0;
    if (rx_cap) begin
      rx_full_d = 1'b1;
      held_d    = rx_data;
    end

    if (cyc_ld) cyc_d = datao;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      rx_full_q <= 1'b0;
      held_q    <= 8'h00;
      cyc_q     <= 32'h0;
      la_q      <= 32'h0;
      lr_q      <= 1'b1;
      lv_q      <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      rx_full_q <= rx_full_d;
      held_q    <= held_d;
      cyc_q     <= cyc_d;
      la_q      <= la_d;
      lr_q      <= lr_d;
      lv_q      <= lv_d;
    end
  end

  // RAM writes repeat on every cycle of a held write; rewriting the same
  // word is harmless. RAM survives reset.
  always_ff @(posedge clk) begin
    if (ram_wr) ram[address[ADDR_BITS-1:0]] <= datao;
  end

  always_ff @(posedge clk) begin
    if (tx_push) fifo_mem[wptr_q] <= datao[7:0];
  end

  // STATUS count field saturates at 15 so deeper FIFOs still fit 4 bits.
  always_comb begin
    cnt_ext = 32'(cnt_q);
    cnt_sat = (cnt_ext > 32'd15) ? 4'hF : cnt_ext[3:0];
  end

  // Read mux: unmapped space and unused MMIO offsets read as zero.
  always_comb begin
    data = 32'h0;
    if (is_ram) begin
      data = ram[address[ADDR_BITS-1:0]];
    end else if (is_mmio) begin
      case (offset)
        8'h01:   data = {24'b0, cnt_sat, ovf_q, rx_full_q, tx_empty, tx_full};
        8'h02:   data = {23'b0, rx_full_q, held_q};
        8'h03:   data = cyc_q;
        default: data = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus a randomized
// phase, all compared against a queue/array reference model of the bus rules.
module tb_mem_responder;
  localparam int          AB      = 10;
  localparam int          FD      = 8;
  localparam logic [31:0] RAM_TOP = 32'd1024;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] address = 32'h0;
  logic [31:0] datao = 32'h0;
  logic        rw = 1'b1;
  logic [31:0] data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_BITS(AB), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .address(address), .datao(datao), .rw(rw),
    .data(data), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_ram [int];
  logic [7:0]  m_q [$];
  bit          m_ovf, m_rxf, m_lr, m_lv;
  bit   [7:0]  m_held;
  bit   [31:0] m_cyc, m_la;

  task automatic model_reset();
    m_q.delete();
    m_ovf = 0; m_rxf = 0; m_held = 8'h00; m_cyc = 32'h0;
    m_la = 32'h0; m_lr = 1; m_lv = 0;
  endtask

  function automatic void model_read(input logic [31:0] a, output logic [31:0] v, output bit known);
    int n;
    n = m_q.size();
    v = 32'h0;
    known = 1;
    if (a < RAM_TOP) begin
      if (m_ram.exists(int'(a))) v = m_ram[int'(a)];
      else known = 0;
    end else if (a[31:8] == 24'hFFFFFF) begin
      case (a[7:0])
        8'h01: begin
          v[7:4] = (n > 15) ? 4'hF : 4'(n);
          v[3] = m_ovf; v[2] = m_rxf; v[1] = (n == 0); v[0] = (n == FD);
        end
        8'h02: begin v[8] = m_rxf; v[7:0] = m_held; end
        8'h03: v = m_cyc;
        default: v = 32'h0;
      endcase
    end
  endfunction

  task automatic model_step();
    bit na, mm, pop, rxf0;
    int n0;
    logic [7:0] off;
    if (reset == 1'b0) return;
    na   = !m_lv || (address != m_la) || (rw != m_lr);
    mm   = (address[31:8] == 24'hFFFFFF);
    off  = address[7:0];
    n0   = m_q.size();
    pop  = (n0 != 0) && tx_ready;
    rxf0 = m_rxf;
    if (!rw && address < RAM_TOP) m_ram[int'(address)] = datao;
    if (pop) void'(m_q.pop_front());
    if (mm && off == 8'h00 && !rw && na) begin
      if (n0 < FD || pop) m_q.push_back(datao[7:0]);
      else m_ovf = 1;
    end
    if (mm && off == 8'h01 && !rw && na) m_ovf = 0;
    if (mm && off == 8'h02 && rw && na) m_rxf = 0;
    if (rx_valid && !rxf0) begin m_rxf = 1; m_held = rx_data; end
    if (mm && off == 8'h03 && !rw && na) m_cyc = datao;
    else m_cyc = m_cyc + 32'd1;
    m_la = address; m_lr = rw; m_lv = 1;
  endtask

  // One clock: compare outputs at the falling edge, advance the model at the
  // rising edge, return 1 time unit later so the caller can drive inputs.
  task automatic tick();
    logic [31:0] exp;
    bit known;
    @(negedge clk);
    model_read(address, exp, known);
    if (known) chk("data", data, exp);
    chk("tx_valid", 32'(tx_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) chk("tx_data", 32'(tx_data), 32'(m_q[0]));
    chk("rx_ready", 32'(rx_ready), 32'(!m_rxf));
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_bus(input logic [31:0] a, input logic r, input logic [31:0] d);
    address = a; rw = r; datao = d;
  endtask

  task automatic idle();
    set_bus(32'h0000_8000, 1'b1, 32'h0);
    tick();
  endtask

  task automatic mmio_wr(input logic [7:0] off, input logic [31:0] v);
    set_bus({24'hFFFFFF, off}, 1'b0, v);
    tick();
    idle();
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 9))
      0, 1, 2: return 32'($urandom_range(0, 15));
      3, 7:    return 32'hFFFFFF00;
      4:       return 32'hFFFFFF01;
      5:       return 32'hFFFFFF02;
      6:       return 32'hFFFFFF03;
      8:       return ($urandom_range(0, 1) == 0) ? 32'h0000_0400 : 32'hFFFFFF10;
      default: return 32'd1023;
    endcase
  endfunction

  initial begin
    model_reset();
    // 1: reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    set_bus(32'hFFFFFF01, 1'b1, 32'h0);
    #1;
    chk("rst_tx_valid", 32'(tx_valid), 32'h0);
    chk("rst_rx_ready", 32'(rx_ready), 32'h1);
    chk("rst_status", data, 32'h02);
    set_bus(32'hFFFFFF03, 1'b1, 32'h0);
    #1;
    chk("rst_cycle", data, 32'h0);
    tick();
    tick();

    // 2: RAM write/read, unmapped read
    set_bus(32'd5, 1'b0, 32'hDEADBEEF);
    tick();
    set_bus(32'd5, 1'b1, 32'h0);
    #1;
    chk("ram_rd5", data, 32'hDEADBEEF);
    tick();
    set_bus(RAM_TOP, 1'b1, 32'h0);
    #1;
    chk("unmapped_rd", data, 32'h0);
    tick();

    // 3: TX push three bytes, then drain in order
    tx_ready = 1'b0;
    mmio_wr(8'h00, 32'h41);
    mmio_wr(8'h00, 32'h42);
    mmio_wr(8'h00, 32'h43);
    set_bus(32'hFFFFFF01, 1'b1, 32'h0);
    #1;
    chk("status_cnt3", data, 32'h30);
    tx_ready = 1'b1;
    #1;
    chk("tx_head0", 32'(tx_data), 32'h41);
    tick();
    #1;
    chk("tx_head1", 32'(tx_data), 32'h42);
    tick();
    #1;
    chk("tx_head2", 32'(tx_data), 32'h43);
    tick();
    #1;
    chk("tx_drained", 32'(tx_valid), 32'h0);
    tx_ready = 1'b0;

    // 4: held write pushes once; overflow sets ovf; STATUS write clears it
    set_bus(32'hFFFFFF00, 1'b0, 32'h55);
    tick(); tick(); tick();
    idle();
    set_bus(32'hFFFFFF01, 1'b1, 32'h0);
    #1;
    chk("hold_one_push", data, 32'h10);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) mmio_wr(8'h00, 32'h60 + 32'(i));
    set_bus(32'hFFFFFF01, 1'b1, 32'h0);
    #1;
    chk("status_full_ovf", data, 32'h89);
    tick();
    set_bus(32'hFFFFFF01, 1'b0, 32'h0);
    tick();
    set_bus(32'hFFFFFF01, 1'b1, 32'h0);
    #1;
    chk("ovf_cleared", data, 32'h81);
    tick();
    tx_ready = 1'b1;
    for (int i = 0; i < FD; i++) tick();
    tx_ready = 1'b0;
    #1;
    chk("drain_full", 32'(tx_valid), 32'h0);

    // 5: RX capture, pop, empty pop
    rx_valid = 1'b1; rx_data = 8'hA5;
    tick();
    rx_valid = 1'b0;
    #1;
    chk("rx_full_rdy", 32'(rx_ready), 32'h0);
    set_bus(32'hFFFFFF02, 1'b1, 32'h0);
    #1;
    chk("rx_pop_data", data, 32'h1A5);
    tick();
    #1;
    chk("rx_after_pop", 32'(rx_ready), 32'h1);
    idle();
    set_bus(32'hFFFFFF02, 1'b1, 32'h0);
    #1;
    chk("rx_empty_pop", data, 32'h0A5);
    tick();

    // 6: CYCLE load and wrap
    set_bus(32'hFFFFFF03, 1'b0, 32'hFFFFFFFE);
    tick();
    set_bus(32'hFFFFFF03, 1'b1, 32'h0);
    #1;
    chk("cyc_loaded", data, 32'hFFFFFFFE);
    tick();
    #1;
    chk("cyc_max", data, 32'hFFFFFFFF);
    tick();
    #1;
    chk("cyc_wrap", data, 32'h0);
    tick();

    // 6: reset mid-operation with bytes queued; RAM survives
    for (int i = 0; i < 4; i++) mmio_wr(8'h00, 32'h70 + 32'(i));
    reset = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_tx_valid", 32'(tx_valid), 32'h0);
    chk("mid_rst_tx_data", 32'(tx_data), 32'h0);
    chk("mid_rst_rx_ready", 32'(rx_ready), 32'h1);
    set_bus(32'd5, 1'b1, 32'h0);
    #1;
    chk("ram_kept", data, 32'hDEADBEEF);
    tick();
    reset = 1'b1;
    set_bus(32'hFFFFFF01, 1'b1, 32'h0);
    #1;
    chk("mid_rst_status", data, 32'h02);
    tick();

    // Randomized traffic with held accesses of 1..3 cycles
    for (int i = 0; i < 600; i++) begin
      int hold;
      set_bus(pick_addr(), 1'($urandom_range(0, 1)), $urandom());
      tx_ready = 1'($urandom_range(0, 1));
      rx_valid = 1'($urandom_range(0, 1));
      rx_data  = 8'($urandom());
      hold = int'($urandom_range(1, 3));
      for (int h = 0; h < hold; h++) tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
